// File: rtl/axi_pkg.sv
// Shared definitions for the AXI register slice: per-channel payload widths
// and the skid buffer occupancy encoding.
package axi_pkg;

  // Bit 0 = main register valid, bit 1 = skid register valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } skid_state_e;

  // Packed payload widths per channel, as a function of the ID width.
  function automatic int AW_PW(input int idw);
    return 54 + idw;
  endfunction

  function automatic int W_PW(input int idw);
    return 74 + idw;
  endfunction

  function automatic int B_PW(input int idw);
    return 3 + idw;
  endfunction

  function automatic int AR_PW(input int idw);
    return 50 + idw;
  endfunction

  function automatic int R_PW(input int idw);
    return 68 + idw;
  endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry skid buffer for one valid/ready channel. in_ready and out_valid
// both come straight from flops, so no combinational path crosses the slice.
// With P_REG=0 the channel collapses to plain wires.
module axi_skid_buf #(
  parameter int P_WIDTH = 8,
  parameter int P_REG   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] out_data
);
  import axi_pkg::*;

  if (P_REG != 0) begin : g_reg
    skid_state_e        state_p1, state_n;
    logic               ready_p1;
    logic [P_WIDTH-1:0] main_data_p1;
    logic [P_WIDTH-1:0] skid_data_p1;
    logic               accept, pop;
    logic               load_main, load_skid, skid_to_main;

    assign accept    = in_valid & ready_p1;
    assign pop       = state_p1[0] & out_ready;
    assign in_ready  = ready_p1;
    assign out_valid = state_p1[0];
    assign out_data  = main_data_p1;

    // Next occupancy and which register captures data this cycle.
    always_comb begin
      state_n      = state_p1;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      case (state_p1)
        EMPTY: begin
          if (accept) begin
            state_n   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_n      = ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end

    // Occupancy and registered ready; ready stays low throughout reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_p1 <= EMPTY;
        ready_p1 <= 1'b0;
      end else begin
        state_p1 <= state_n;
        ready_p1 <= (state_n != FULL);
      end
    end

    // Main register: cleared on reset so the output payload reads zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        main_data_p1 <= '0;
      end else if (load_main) begin
        main_data_p1 <= in_data;
      end else if (skid_to_main) begin
        main_data_p1 <= skid_data_p1;
      end
    end

    // Skid register: only meaningful while FULL, so it needs no reset.
    always_ff @(posedge clk) begin
      if (load_skid) begin
        skid_data_p1 <= in_data;
      end
    end
  end else begin : g_wire
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
  end

endmodule

// File: rtl/axi_reg_slice_1.sv
// Five-channel AXI register slice. Each channel is packed into a flat vector,
// passed through its own skid buffer, and unpacked on the far side.
module axi_reg_slice_1 #(
  parameter int P_AXI_IDWIDTH = 5,
  parameter int P_AW_REG      = 1,
  parameter int P_W_REG       = 1,
  parameter int P_B_REG       = 1,
  parameter int P_AR_REG      = 1,
  parameter int P_R_REG       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  // slave-side AW
  input  logic [31:0]              axis_awaddr,
  input  logic [7:0]               axis_awlen,
  input  logic [2:0]               axis_awsize,
  input  logic [1:0]               axis_awburst,
  input  logic [P_AXI_IDWIDTH-1:0] axis_awid,
  input  logic                     axis_awlock,
  input  logic [3:0]               axis_awcache,
  input  logic [2:0]               axis_awprot,
  input  logic                     axis_awuser,
  input  logic                     axis_awvalid,
  output logic                     axis_awready,
  // slave-side W
  input  logic [P_AXI_IDWIDTH-1:0] axis_wid,
  input  logic [63:0]              axis_wdata,
  input  logic [7:0]               axis_wstrb,
  input  logic                     axis_wlast,
  input  logic                     axis_wuser,
  input  logic                     axis_wvalid,
  output logic                     axis_wready,
  // slave-side B
  output logic [P_AXI_IDWIDTH-1:0] axis_bid,
  output logic [1:0]               axis_bresp,
  output logic                     axis_buser,
  output logic                     axis_bvalid,
  input  logic                     axis_bready,
  // slave-side AR
  input  logic [P_AXI_IDWIDTH-1:0] axis_arid,
  input  logic [31:0]              axis_araddr,
  input  logic [3:0]               axis_arlen,
  input  logic [2:0]               axis_arsize,
  input  logic [1:0]               axis_arburst,
  input  logic                     axis_arlock,
  input  logic [3:0]               axis_arcache,
  input  logic [2:0]               axis_arprot,
  input  logic                     axis_aruser,
  input  logic                     axis_arvalid,
  output logic                     axis_arready,
  // slave-side R
  output logic [P_AXI_IDWIDTH-1:0] axis_rid,
  output logic [63:0]              axis_rdata,
  output logic [1:0]               axis_rresp,
  output logic                     axis_rlast,
  output logic                     axis_ruser,
  output logic                     axis_rvalid,
  input  logic                     axis_rready,
  // master-side AW
  output logic [31:0]              axim_awaddr,
  output logic [7:0]               axim_awlen,
  output logic [2:0]               axim_awsize,
  output logic [1:0]               axim_awburst,
  output logic [P_AXI_IDWIDTH-1:0] axim_awid,
  output logic                     axim_awlock,
  output logic [3:0]               axim_awcache,
  output logic [2:0]               axim_awprot,
  output logic                     axim_awuser,
  output logic                     axim_awvalid,
  input  logic                     axim_awready,
  // master-side W
  output logic [P_AXI_IDWIDTH-1:0] axim_wid,
  output logic [63:0]              axim_wdata,
  output logic [7:0]               axim_wstrb,
  output logic                     axim_wlast,
  output logic                     axim_wuser,
  output logic                     axim_wvalid,
  input  logic                     axim_wready,
  // master-side B
  input  logic [P_AXI_IDWIDTH-1:0] axim_bid,
  input  logic [1:0]               axim_bresp,
  input  logic                     axim_buser,
  input  logic                     axim_bvalid,
  output logic                     axim_bready,
  // master-side AR
  output logic [P_AXI_IDWIDTH-1:0] axim_arid,
  output logic [31:0]              axim_araddr,
  output logic [3:0]               axim_arlen,
  output logic [2:0]               axim_arsize,
  output logic [1:0]               axim_arburst,
  output logic                     axim_arlock,
  output logic [3:0]               axim_arcache,
  output logic [2:0]               axim_arprot,
  output logic                     axim_aruser,
  output logic                     axim_arvalid,
  input  logic                     axim_arready,
  // master-side R
  input  logic [P_AXI_IDWIDTH-1:0] axim_rid,
  input  logic [63:0]              axim_rdata,
  input  logic [1:0]               axim_rresp,
  input  logic                     axim_rlast,
  input  logic                     axim_ruser,
  input  logic                     axim_rvalid,
  output logic                     axim_rready
);
  import axi_pkg::*;

  localparam int AW_W = AW_PW(P_AXI_IDWIDTH);
  localparam int W_W  = W_PW(P_AXI_IDWIDTH);
  localparam int B_W  = B_PW(P_AXI_IDWIDTH);
  localparam int AR_W = AR_PW(P_AXI_IDWIDTH);
  localparam int R_W  = R_PW(P_AXI_IDWIDTH);

  logic [AW_W-1:0] aw_in, aw_out;
  logic [W_W-1:0]  w_in,  w_out;
  logic [B_W-1:0]  b_in,  b_out;
  logic [AR_W-1:0] ar_in, ar_out;
  logic [R_W-1:0]  r_in,  r_out;

  assign aw_in = {axis_awid, axis_awaddr, axis_awlen, axis_awsize, axis_awburst,
                  axis_awlock, axis_awcache, axis_awprot, axis_awuser};
  assign {axim_awid, axim_awaddr, axim_awlen, axim_awsize, axim_awburst,
          axim_awlock, axim_awcache, axim_awprot, axim_awuser} = aw_out;

  assign w_in = {axis_wid, axis_wdata, axis_wstrb, axis_wlast, axis_wuser};
  assign {axim_wid, axim_wdata, axim_wstrb, axim_wlast, axim_wuser} = w_out;

  assign b_in = {axim_bid, axim_bresp, axim_buser};
  assign {axis_bid, axis_bresp, axis_buser} = b_out;

  assign ar_in = {axis_arid, axis_araddr, axis_arlen, axis_arsize, axis_arburst,
                  axis_arlock, axis_arcache, axis_arprot, axis_aruser};
  assign {axim_arid, axim_araddr, axim_arlen, axim_arsize, axim_arburst,
          axim_arlock, axim_arcache, axim_arprot, axim_aruser} = ar_out;

  assign r_in = {axim_rid, axim_rdata, axim_rresp, axim_rlast, axim_ruser};
  assign {axis_rid, axis_rdata, axis_rresp, axis_rlast, axis_ruser} = r_out;

  axi_skid_buf #(.P_WIDTH(AW_W), .P_REG(P_AW_REG)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid(axis_awvalid), .in_ready(axis_awready), .in_data(aw_in),
    .out_valid(axim_awvalid), .out_ready(axim_awready), .out_data(aw_out)
  );

  axi_skid_buf #(.P_WIDTH(W_W), .P_REG(P_W_REG)) u_w (
    .clk(clk), .rst(rst),
    .in_valid(axis_wvalid), .in_ready(axis_wready), .in_data(w_in),
    .out_valid(axim_wvalid), .out_ready(axim_wready), .out_data(w_out)
  );

  axi_skid_buf #(.P_WIDTH(B_W), .P_REG(P_B_REG)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(axim_bvalid), .in_ready(axim_bready), .in_data(b_in),
    .out_valid(axis_bvalid), .out_ready(axis_bready), .out_data(b_out)
  );

  axi_skid_buf #(.P_WIDTH(AR_W), .P_REG(P_AR_REG)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid(axis_arvalid), .in_ready(axis_arready), .in_data(ar_in),
    .out_valid(axim_arvalid), .out_ready(axim_arready), .out_data(ar_out)
  );

  axi_skid_buf #(.P_WIDTH(R_W), .P_REG(P_R_REG)) u_r (
    .clk(clk), .rst(rst),
    .in_valid(axim_rvalid), .in_ready(axim_rready), .in_data(r_in),
    .out_valid(axis_rvalid), .out_ready(axis_rready), .out_data(r_out)
  );

endmodule
